// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared NoC flit layout, flit type enum and width helper
package ravenoc_pkg;
  localparam int FlitWidth = 34;
  localparam int PktWidth = 8;
  localparam int MinDataWidth = 22;
  localparam int TypeLsb = 32;
  localparam int PktLsb = 22;
  typedef enum logic [1:0] {HEAD_FLIT = 2'd0, BODY_FLIT = 2'd1, TAIL_FLIT = 2'd2} flit_t;
  function automatic int MinBitWidth(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or after ptr
module rr_arbiter
  import ravenoc_pkg::*;
#(
  parameter int N = 4,
  localparam int W = MinBitWidth(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_any,
  output logic [W-1:0] gnt_idx
);
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_any && req[(int'(ptr) + i) % N]) begin
        gnt_any = 1'b1;
        gnt_idx = W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/vc_out_arbiter.sv
// vc_out_arbiter: wormhole round-robin merge of NUM_IN flit streams onto one registered link
module vc_out_arbiter
  import ravenoc_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int FLIT_W = FlitWidth,
  localparam int W = MinBitWidth(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NUM_IN*FLIT_W-1:0] fdata_i,
  input  logic [NUM_IN-1:0]        valid_i,
  output logic [NUM_IN-1:0]        ready_o,
  output logic [FLIT_W-1:0]        fdata_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [W-1:0]             owner_o,
  output logic                     error_o
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_d;
  logic slot_free, win_any, xfer, proto_err;
  logic [W-1:0] win_idx, sel, rr_ptr;
  logic [NUM_IN-1:0] head_req;
  logic [FLIT_W-1:0] sel_flit;
  flit_t sel_type;
  assign slot_free = ~valid_o | ready_i;
  always_comb begin
    head_req = '0;
    for (int k = 0; k < NUM_IN; k++)
      head_req[k] = valid_i[k] && fdata_i[k*FLIT_W+TypeLsb +: 2] == HEAD_FLIT;
  end
  rr_arbiter #(.N(NUM_IN)) u_rr (
    .req    (head_req),
    .ptr    (rr_ptr),
    .gnt_any(win_any),
    .gnt_idx(win_idx)
  );
  // While locked only the owner is eligible; in IDLE the head-flit winner is
  assign sel = (state == LOCKED) ? owner_o : win_idx;
  assign sel_flit = fdata_i[int'(sel)*FLIT_W +: FLIT_W];
  assign sel_type = flit_t'(sel_flit[TypeLsb +: 2]);
  assign ready_o = ((state == LOCKED || win_any) && slot_free) ? NUM_IN'(1) << sel : '0;
  assign xfer = |(valid_i & ready_o);
  assign proto_err = (state == IDLE) ? |(valid_i & ~head_req) : xfer && sel_type == HEAD_FLIT;
  always_comb begin
    state_d = state;
    if (xfer)
      state_d = (state == IDLE) ? ((sel_flit[PktLsb +: PktWidth] != '0) ? LOCKED : IDLE)
                                : ((sel_type == TAIL_FLIT) ? IDLE : LOCKED);
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner_o <= '0;
      fdata_o <= '0;
      valid_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      state   <= state_d;
      error_o <= error_o | proto_err;
      if (xfer) begin
        fdata_o <= sel_flit;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      if (xfer && state == IDLE) begin
        owner_o <= win_idx;
        rr_ptr  <= (int'(win_idx) == NUM_IN - 1) ? '0 : win_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vc_out_arbiter.sv
// tb_vc_out_arbiter: directed checks of grant order, wormhole lock, backpressure, errors and reset
module tb_vc_out_arbiter;
  localparam int N = 4;
  localparam int FW = 34;
  logic clk = 1'b0;
  logic arst = 1'b0;
  logic [N*FW-1:0] fdata_i = '0;
  logic [N-1:0] valid_i = '0;
  logic [N-1:0] ready_o;
  logic [FW-1:0] fdata_o;
  logic valid_o;
  logic ready_i = 1'b1;
  logic [1:0] owner_o;
  logic error_o;
  int total = 0;
  int bad = 0;
  logic [FW-1:0] f1 [4];
  logic [FW-1:0] f2 [3];
  always #5 clk = ~clk;
  vc_out_arbiter #(.NUM_IN(N), .FLIT_W(FW)) dut (
    .clk    (clk),
    .arst   (arst),
    .fdata_i(fdata_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .fdata_o(fdata_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .owner_o(owner_o),
    .error_o(error_o)
  );
  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] p, input logic [21:0] d);
    return {t, 2'b00, p, d};
  endfunction
  function automatic logic [FW-1:0] hd(input int k);
    return mk(2'd0, 8'd0, 22'(32'h100 + k));
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic put(input int k, input logic [FW-1:0] f);
    fdata_i[k*FW +: FW] = f;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rst;
    arst = 1'b1;
    valid_i = '0;
    ready_i = 1'b1;
    #2;
    arst = 1'b0;
  endtask
  initial begin
    #1 arst = 1'b1;
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_fdata", fdata_o, 0);
    chk("rst_err", error_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_ready", ready_o, 0);
    arst = 1'b0;
    tick;
    // single-flit packet on input 2
    put(2, hd(2));
    valid_i = 4'b0100;
    #1 chk("t1_ready", ready_o, 4'b0100);
    tick;
    valid_i = '0;
    #1;
    chk("t1_valid", valid_o, 1);
    chk("t1_fdata", fdata_o, hd(2));
    chk("t1_owner", owner_o, 2);
    put(0, hd(0));
    put(3, hd(3));
    valid_i = 4'b1001;
    #1 chk("t1_ptr3", ready_o, 4'b1000);
    tick;
    // fairness: all inputs always present single-flit heads
    rst;
    for (int k = 0; k < N; k++) put(k, hd(k));
    valid_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1 chk("rr_ready", ready_o, 64'(1) << (c % 4));
      if (c > 0) begin
        chk("rr_fdata", fdata_o, hd((c - 1) % 4));
        chk("rr_valid", valid_o, 1);
      end
      tick;
    end
    #1 chk("rr_last", fdata_o, hd(0));
    // wormhole lock on input 1 while input 0 waits with a head
    rst;
    f1[0] = mk(2'd0, 8'd3, 22'h11);
    f1[1] = mk(2'd1, 8'd3, 22'h12);
    f1[2] = mk(2'd1, 8'd3, 22'h13);
    f1[3] = mk(2'd2, 8'd3, 22'h14);
    put(0, hd(0));
    for (int i = 0; i < 4; i++) begin
      put(1, f1[i]);
      valid_i = (i == 0) ? 4'b0010 : 4'b0011;
      #1 chk("wh_ready", ready_o, 4'b0010);
      if (i > 0) chk("wh_fdata", fdata_o, f1[i-1]);
      tick;
    end
    valid_i = 4'b0001;
    #1;
    chk("wh_regrant", ready_o, 4'b0001);
    chk("wh_tail", fdata_o, f1[3]);
    chk("wh_tail_v", valid_o, 1);
    tick;
    #1;
    chk("wh_h0", fdata_o, hd(0));
    chk("wh_owner", owner_o, 0);
    tick;
    // backpressure during a locked packet on input 2
    rst;
    f2[0] = mk(2'd0, 8'd2, 22'h21);
    f2[1] = mk(2'd1, 8'd2, 22'h22);
    f2[2] = mk(2'd2, 8'd2, 22'h23);
    put(2, f2[0]);
    valid_i = 4'b0100;
    #1 chk("bp_ready0", ready_o, 4'b0100);
    tick;
    put(2, f2[1]);
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall_rdy", ready_o, 0);
      chk("bp_stall_fd", fdata_o, f2[0]);
      chk("bp_stall_v", valid_o, 1);
      tick;
    end
    ready_i = 1'b1;
    #1 chk("bp_resume", ready_o, 4'b0100);
    tick;
    put(2, f2[2]);
    #1;
    chk("bp_body", fdata_o, f2[1]);
    chk("bp_rdy_t", ready_o, 4'b0100);
    tick;
    valid_i = '0;
    #1;
    chk("bp_tail", fdata_o, f2[2]);
    chk("bp_tail_v", valid_o, 1);
    tick;
    #1 chk("bp_drain", valid_o, 0);
    tick;
    // body flit on input 3 while idle
    rst;
    put(3, mk(2'd1, 8'd0, 22'h31));
    valid_i = 4'b1000;
    #1;
    chk("pe_ready", ready_o, 0);
    chk("pe_err0", error_o, 0);
    tick;
    valid_i = '0;
    #1 chk("pe_err1", error_o, 1);
    tick;
    tick;
    #1 chk("pe_sticky", error_o, 1);
    tick;
    // reset mid-packet (error still set from above)
    put(1, mk(2'd0, 8'd3, 22'h41));
    valid_i = 4'b0010;
    #1 chk("mr_ready", ready_o, 4'b0010);
    tick;
    put(1, mk(2'd1, 8'd3, 22'h42));
    tick;
    arst = 1'b1;
    #1;
    chk("mr_valid", valid_o, 0);
    chk("mr_err", error_o, 0);
    chk("mr_owner", owner_o, 0);
    chk("mr_rdy", ready_o, 0);
    arst = 1'b0;
    put(0, hd(0));
    put(1, hd(1));
    put(3, hd(3));
    valid_i = 4'b1011;
    #1 chk("mr_first", ready_o, 4'b0001);
    tick;
    valid_i = '0;
    #1;
    chk("mr_fdata", fdata_o, hd(0));
    chk("mr_own0", owner_o, 0);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
